// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing a 3-to-8 decoder among requesters.
// Bounded grant tenure with a one-cycle enable-low gap between grants.
module decoder_rr_arbiter #(
  parameter int unsigned NREQ     = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt, winner_c, cand_c;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             any_req_c, release_c, expire_c, timeout_nxt;

  assign any_req_c = |req;
  assign release_c = done[sel] | ~req[sel];
  assign expire_c  = (hold_cnt == CNT_W'(MAX_HOLD));

  // First requester at or after ptr; lowest offset wins since it is assigned last.
  always_comb begin
    winner_c = ptr;
    cand_c   = ptr;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand_c = SEL_W'(ptr + SEL_W'(k));
      if (req[cand_c]) winner_c = cand_c;
    end
  end

  // State register plus registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      en       <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      en       <= (state_nxt == GRANT);
      busy     <= (state_nxt != IDLE);
      timeout  <= timeout_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req_c) state_nxt = GRANT;
      GRANT:   if (release_c || expire_c) state_nxt = GAP;
      GAP:     state_nxt = any_req_c ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of select, pointer, tenure counter and timeout pulse.
  always_comb begin
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (any_req_c) begin
          sel_nxt      = winner_c;
          hold_cnt_nxt = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_c || expire_c) begin
          // NREQ is a power of two, so the increment wraps 7 -> 0 naturally.
          ptr_nxt     = SEL_W'(sel + SEL_W'(1));
          timeout_nxt = expire_c & ~release_c;
        end else begin
          hold_cnt_nxt = CNT_W'(hold_cnt + CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

endmodule
